// File: rtl/alu_exec_stage.sv
// Registered MIPS ALU execute stage: valid/ready output register plus sticky overflow.
// Optional perf counters (perf_ops, perf_stall) are enabled by defining ALU_EXEC_PERF_CNT_EN.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctr,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             ovf_clr
`ifdef ALU_EXEC_PERF_CNT_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stall
`endif
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ADDU = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SUBU = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_NOR  = 3'b111;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             sum_ovf;
    logic             diff_ovf;
    logic             lt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             accept;
    logic             load;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             sticky_q;

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    assign sum_ovf  = (src_a[MSB] == src_b[MSB]) && (sum[MSB] != src_a[MSB]);
    assign diff_ovf = (src_a[MSB] != src_b[MSB]) && (diff[MSB] != src_a[MSB]);

    // Direct signed compare, so SLT never suffers from the subtract overflow.
    assign lt = $signed(src_a) < $signed(src_b);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (alu_ctr)
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = sum_ovf;
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = diff_ovf;
            end
            OP_SUBU: alu_res = diff;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
            OP_NOR:  alu_res = ~(src_a | src_b);
        endcase
    end

    assign in_ready = (state_q == EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (load) begin
            result_q <= alu_res;
            zero_q   <= (alu_res == '0);
            ovf_q    <= alu_ovf;
        end
    end

    // Clear beats a coincident overflow so software never misses its own clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (ovf_clr) begin
            sticky_q <= 1'b0;
        end else if (accept && alu_ovf) begin
            sticky_q <= 1'b1;
        end
    end

    assign out_valid  = (state_q == FULL);
    assign result     = result_q;
    assign zero       = zero_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

`ifdef ALU_EXEC_PERF_CNT_EN
    logic [31:0] ops_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else begin
            if (accept && (ops_q != 32'hFFFF_FFFF)) begin
                ops_q <= ops_q + 32'd1;
            end
            if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_ops   = ops_q;
    assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: randomized ops checked against a signed-integer model.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alu_ctr = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        ovf_sticky;
    logic        ovf_clr = 1'b0;
`ifdef ALU_EXEC_PERF_CNT_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;
`endif

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_ctr    (alu_ctr),
        .src_a      (src_a),
        .src_b      (src_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
`ifdef ALU_EXEC_PERF_CNT_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   m_sticky = 1'b0;
    int   stall_left = 0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: exact signed integer arithmetic, then wrap to 32 bits.
    function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        full = 0;
        e.o = 1'b0;
        case (c)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: begin
                full = sa + sb;
                e.res = full[31:0];
                e.o = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            3'd3: begin
                full = longint'(a) + longint'(b);
                e.res = full[31:0];
            end
            3'd4: begin
                full = sa - sb;
                e.res = full[31:0];
                e.o = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            3'd5: begin
                full = longint'(a) - longint'(b);
                e.res = full[31:0];
            end
            3'd6: e.res = (sa < sb) ? 32'd1 : 32'd0;
            default: e.res = ~(a | b);
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("result", result, q[0].res);
                chk("zero", {31'd0, zero}, {31'd0, q[0].z});
                chk("ovf", {31'd0, ovf}, {31'd0, q[0].o});
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = 1'b0;
        if (!rst) begin
            chk("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, m_sticky});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (in_valid && in_ready) begin
                acc = 1'b1;
                e = model(alu_ctr, src_a, src_b);
                q.push_back(e);
            end
            if (ovf_clr) m_sticky = 1'b0;
            else if (acc && e.o) m_sticky = 1'b1;
        end
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic clr, output int waits);
        bit acc;
        in_valid = 1'b1;
        alu_ctr  = c;
        src_a    = a;
        src_b    = b;
        ovf_clr  = clr;
        waits    = 0;
        do begin
            step(acc);
            ovf_clr = 1'b0;
            waits++;
        end while (!acc && waits < 100);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            step(acc);
            n++;
        end
        chk("drain_left", q.size(), 32'd0);
    endtask

    task automatic do_reset();
        bit acc;
        rst = 1'b1;
        in_valid = 1'b1;
        alu_ctr = 3'd2;
        src_a = $urandom;
        src_b = $urandom;
        for (int i = 0; i < 2; i++) begin
            step(acc);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_result", result, 32'd0);
            chk("rst_zero", {31'd0, zero}, 32'd0);
            chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
        end
        q.delete();
        m_sticky = 1'b0;
        stall_left = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        step(acc);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_result", result, 32'd0);
        chk("post_rst_zero", {31'd0, zero}, 32'd0);
        chk("post_rst_sticky", {31'd0, ovf_sticky}, 32'd0);
`ifdef ALU_EXEC_PERF_CNT_EN
        chk("rst_perf_ops", perf_ops, 32'd0);
        chk("rst_perf_stall", perf_stall, 32'd0);
`endif
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit acc;
        @(posedge clk);
        #1;
        do_reset();

        for (int c = 0; c < 8; c++) begin
            issue(3'(c), 32'h0000_000F, 32'h0000_0005, 1'b0, w);
        end
        drain();

        issue(3'd2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, w);
        issue(3'd3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, w);
        issue(3'd4, 32'h8000_0000, 32'h0000_0001, 1'b0, w);
        drain();
        chk("sticky_after_ovf", {31'd0, ovf_sticky}, 32'd1);
        ovf_clr = 1'b1;
        step(acc);
        ovf_clr = 1'b0;
        step(acc);
        chk("sticky_after_clr", {31'd0, ovf_sticky}, 32'd0);
        issue(3'd2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, w);
        drain();
        chk("sticky_clr_wins", {31'd0, ovf_sticky}, 32'd0);

        issue(3'd6, 32'h8000_0000, 32'h0000_0001, 1'b0, w);
        issue(3'd6, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, w);
        drain();

        do_reset();
        stall_left = 3;
        issue(3'd2, 32'd100, 32'd1, 1'b0, w);
        issue(3'd2, 32'd200, 32'd2, 1'b0, w);
        chk("bp_stall_waits", w, 32'd4);
        issue(3'd2, 32'd300, 32'd3, 1'b0, w);
        chk("bp_b2b_waits3", w, 32'd1);
        issue(3'd2, 32'd400, 32'd4, 1'b0, w);
        chk("bp_b2b_waits4", w, 32'd1);
        drain();
`ifdef ALU_EXEC_PERF_CNT_EN
        chk("perf_ops", perf_ops, 32'd4);
        chk("perf_stall", perf_stall, 32'd3);
`endif

        stall_left = 5;
        issue(3'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, w);
        in_valid = 1'b1;
        step(acc);
        step(acc);
        do_reset();

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                src_a = $urandom;
                alu_ctr = 3'($urandom);
                step(acc);
            end
            issue(3'($urandom), pick(), pick(), ($urandom_range(0, 7) == 0), w);
        end
        rand_ready = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage directly downstream of the ALU controller in the MIPS datapath.
- Consumes the 3-bit ALU control code and two operands, and computes the result and flags.
- Holds the result in an output pipeline register with a valid/ready handshake, so the multi-cycle datapath and testbenches can backpressure it.
- Also keeps a sticky overflow indicator for the exception logic.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and alu_ctr are valid this cycle.
- in_ready  output  1  stage can accept an operation this cycle.
- alu_ctr  input  3  operation code from the ALU controller.
- src_a  input  WIDTH  operand A (rs).
- src_b  input  WIDTH  operand B (rt or immediate).
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  registered result.
- zero  output  1  registered; result == 0.
- ovf  output  1  registered; signed overflow of this result (ADD/SUB only).
- ovf_sticky  output  1  set by any accepted op with overflow; cleared by ovf_clr.
- ovf_clr  input  1  clears ovf_sticky.

Behaviour:
- Reset values:
  - Clock/reset: one clock, clk; synchronous active-high reset, rst.
  - While rst is high at a clock edge, all outputs go to 0: out_valid=0, result=0, zero=0, ovf=0, ovf_sticky=0 (and perf counters when enabled).
  - The reset value of zero is 0, not 1.
  - Reset mid-operation discards any held result; nothing is emitted.
- alu_ctr encoding:
  - 000 AND
  - 001 OR
  - 010 ADD (signed, overflow detected)
  - 011 ADDU
  - 100 SUB (A−B, signed, overflow detected)
  - 101 SUBU
  - 110 SLT (signed A<B → 1, else 0, zero-extended)
  - 111 NOR
- Arithmetic:
  - Modulo 2^WIDTH; the result is always written, even on overflow.
  - ADD overflow = operands with equal sign and a result of different sign.
  - SUB overflow = operands with different sign and result sign ≠ sign of A.
  - ovf = 0 for all other codes.
  - SLT is evaluated without overflow error: the comparison is correct for, e.g., A=0x80000000, B=1.
- Handshake:
  - Accept = in_valid && in_ready.
  - Transfer = out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational).
- Latency: an operation accepted in cycle N appears with out_valid=1 in cycle N+1.
- Result hold: result, zero and ovf stay stable while out_valid && !out_ready.
- Register update: on accept, the result register loads and out_valid=1. On transfer without accept, out_valid=0. Simultaneous transfer and accept sustains back-to-back throughput of 1 op/cycle.
- Idle inputs: in_valid=0 leaves the register untouched; operand and alu_ctr values are ignored when not accepted.
- ovf_sticky:
  - Set on accept when the computed ovf=1.
  - ovf_clr has priority over a simultaneous set: clear wins, and that op's overflow is not recorded in the sticky bit. Its ovf output is still 1.
- States, implicit in out_valid:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on transfer without accept.
  - FULL → FULL on transfer with accept, or on stall.

Optional Feature:
- Macro: ALU_EXEC_PERF_CNT_EN.
- Defined: adds output ports perf_ops[31:0] and perf_stall[31:0].
  - perf_ops counts accepts.
  - perf_stall counts cycles with out_valid && !out_ready.
  - Both saturate at 0xFFFFFFFF, reset to 0, and are unaffected by ovf_clr.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 → out_valid=0, result=0, zero=0, ovf_sticky=0 throughout and one cycle after release.
- Operation sweep: out_ready=1; A=0x0000000F, B=0x00000005, codes 000..111 → results 0x5, 0xF, 0x14, 0x14, 0xA, 0xA, 0x0 (zero=1), 0xFFFFFFF0, each one cycle after accept.
- Overflow:
  - ADD 0x7FFFFFFF+1 → result 0x80000000, ovf=1, ovf_sticky=1.
  - ADDU same operands → ovf=0.
  - SUB 0x80000000−1 → 0x7FFFFFFF, ovf=1.
  - Pulse ovf_clr → sticky=0.
  - ovf_clr coincident with an overflowing ADD → sticky stays 0.
- Signed compare: SLT A=0x80000000, B=1 → result 1; SLT A=1, B=0xFFFFFFFF → result 0.
- Backpressure: stream 4 ADDs with out_ready=0 for 3 cycles after the first → in_ready=0 and result held at the first value; release → all 4 results delivered in order, no loss or duplication, 1/cycle.
- Perf counters (ALU_EXEC_PERF_CNT_EN): previous scenario → perf_ops=4, perf_stall=3; a mid-stream rst → out_valid=0 and counters=0.
